control_unit: RTL

Instruction-sequencing state machine that drives the datapath's control inputs. It holds the program counter (PC) and the instruction register (IR), and fetches 16-bit instructions from a synchronous instruction ROM. It decodes each instruction and sequences the datapath's data-memory address, write strobes, register-file addresses and enables, mux select and ALU select through LOAD, STORE, ADD, SUB, NOOP and HALT. It is the initiator side of the datapath control interface; the top level instantiates it beside the datapath and the instruction ROM.

---
 rtl/control_pkg.sv | 44 ++++
 rtl/control_unit_program_counter.sv | 23 ++
 rtl/control_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared opcode, ALU-select and state encodings plus instruction field positions
// for the instruction-sequencing control unit.
package control_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_ZERO   = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_PASS_A = 3'd3;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RA_HI    = 11;
  localparam int RA_LO    = 8;
  localparam int RB_HI    = 7;
  localparam int RB_LO    = 4;
  localparam int RD_HI    = 3;
  localparam int RD_LO    = 0;
  localparam int MADDR_HI = 11;
  localparam int MADDR_LO = 4;

  function automatic logic [3:0] get_op(input logic [15:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// Program counter register: async active-high clear, sync clear, increment enable.
// Wraps modulo 2^PC_W.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving datapath control from registered state and IR.
// Outputs depend only on state and IR, so an async reset drops every strobe at once.
module control_unit
  import control_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     IR_data,
  output logic [PC_W-1:0] PC_addr,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_wr,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic            RF_Ra_rd,
  output logic            RF_Rb_rd,
  output logic [2:0]      Alu_s0,
  output logic [15:0]     IR_out,
  output logic [3:0]      State_out
);

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic        pc_clr;
  logic        pc_inc;

  assign pc_clr = (state == S_INIT);
  assign pc_inc = (state == S_DECODE);

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk (Clock),
    .rst (Reset),
    .clr (pc_clr),
    .inc (pc_inc),
    .pc  (PC_addr)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_INIT) begin
        ir <= '0;
      end else if (state == S_DECODE) begin
        ir <= IR_data;
      end
    end
  end

  // Next state in DECODE comes from the ROM word arriving now, since IR only loads at the edge.
  always_comb begin
    next_state = state;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    RF_Ra_rd   = 1'b0;
    RF_Rb_rd   = 1'b0;
    Alu_s0     = ALU_ZERO;

    case (state)
      S_INIT:  next_state = S_FETCH;
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (get_op(IR_data))
          OP_LOAD:  next_state = S_LOAD_A;
          OP_STORE: next_state = S_STORE;
          OP_ADD:   next_state = S_ADD;
          OP_SUB:   next_state = S_SUB;
          OP_HALT:  next_state = S_HALT;
          default:  next_state = S_FETCH;
        endcase
      end
      S_LOAD_A: begin
        D_addr     = ir[MADDR_HI:MADDR_LO];
        next_state = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_addr     = ir[MADDR_HI:MADDR_LO];
        RF_s       = 1'b1;
        RF_W_addr  = ir[RD_HI:RD_LO];
        RF_W_wr    = 1'b1;
        next_state = S_FETCH;
      end
      S_STORE: begin
        D_addr     = ir[MADDR_HI:MADDR_LO];
        RF_Ra_addr = ir[RD_HI:RD_LO];
        RF_Ra_rd   = 1'b1;
        D_wr       = 1'b1;
        next_state = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir[RA_HI:RA_LO];
        RF_Rb_addr = ir[RB_HI:RB_LO];
        RF_Ra_rd   = 1'b1;
        RF_Rb_rd   = 1'b1;
        Alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_addr  = ir[RD_HI:RD_LO];
        RF_W_wr    = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_INIT;
    endcase
  end

  assign IR_out    = ir;
  assign State_out = state;

endmodule
